// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter with a small TX FIFO.
//
// A CPU store to TX_ADDR queues mem_write_value[7:0]; a store to TX_ADDR+4
// with bit 0 set clears the sticky overflow flag. Bytes leave the FIFO in
// order and are sent as 8N1 frames (start, 8 data bits LSB first, stop),
// each bit lasting CLK_DIV clk cycles. Frames are sent back to back while
// the FIFO holds data.
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   we              CPU store strobe (one cycle per store)
//   mem_address     CPU store byte address
//   mem_write_value CPU store data
//   status          {24'b0, count[3:0], 1'b0, overflow, full, busy}
//   uart_tx         serial output, idle high, registered
module uart_tx_mmio #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] TX_ADDR    = 32'h0000_F000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_value,
    output logic [31:0] status,
    output logic        uart_tx
);

    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] DIV_M1    = 16'(CLK_DIV - 1);
    localparam logic [3:0]  DEPTH_C   = 4'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [31:0] CTRL_ADDR = TX_ADDR + 32'd4;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    state_t           state_nx;
    logic [15:0]      bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;
    logic             tx_nx;
    logic             pop;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [3:0]       count;
    logic             overflow;

    logic             full;
    logic             busy;
    logic             data_wr;
    logic             ctrl_wr;
    logic             push;
    logic             bit_done;
    logic             unused_data_hi;

    assign full     = (count == DEPTH_C);
    assign busy     = (state != IDLE) || (count != '0);
    assign data_wr  = we && (mem_address == TX_ADDR);
    assign ctrl_wr  = we && (mem_address == CTRL_ADDR);
    assign push     = data_wr && !full;
    assign bit_done = (bit_cnt == '0);
    assign status   = {24'b0, count, 1'b0, overflow, full, busy};
    assign unused_data_hi = &{1'b0, mem_write_value[31:8]};

    // State register and bit-timing datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift_q <= '0;
            uart_tx <= 1'b1;
        end else begin
            state <= state_nx;
            // Line flop follows the current state, so the line lags the
            // state register by one cycle.
            uart_tx <= tx_nx;
            if ((state_nx != state) || ((state != IDLE) && bit_done)) begin
                bit_cnt <= DIV_M1;
            end else if (state != IDLE) begin
                bit_cnt <= bit_cnt - 16'd1;
            end
            if (state != DATA) begin
                bit_idx <= '0;
            end else if (bit_done) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (pop) begin
                shift_q <= fifo_mem[rd_ptr];
            end
        end
    end

    // Next-state logic; also decides when the FIFO head is consumed
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop      = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                if (bit_done) state_nx = DATA;
            end
            DATA: begin
                if (bit_done && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) state_nx = STOP;
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (count != '0) begin
                        pop      = 1'b1;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Serial bit for the current state
    always_comb begin
        tx_nx = 1'b1;
        unique case (state)
            IDLE:   tx_nx = 1'b1;
            START:  tx_nx = 1'b0;
            DATA:   tx_nx = shift_q[bit_idx];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_nx = ^shift_q;
`endif
            STOP:   tx_nx = 1'b1;
            default: tx_nx = 1'b1;
        endcase
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_write_value[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            // A write to a full FIFO is dropped even if a pop frees a slot
            // this cycle; set wins over clear.
            if (data_wr && full) begin
                overflow <= 1'b1;
            end else if (ctrl_wr && mem_write_value[0]) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio (CLK_DIV=4, FIFO_DEPTH=4).
// A queue-based model predicts the line and status every cycle; directed
// sequences add hand-computed expectations at key points.
module tb_uart_tx_mmio;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [31:0] TX_ADDR    = 32'h0000_F000;
`ifdef UART_TX_PARITY_EN
    localparam int NSLOT    = 11;
    localparam int BUSY_END = 45;
    localparam int DRAIN5   = 217;
`else
    localparam int NSLOT    = 10;
    localparam int BUSY_END = 41;
    localparam int DRAIN5   = 197;
`endif
    localparam int FRAME = NSLOT * CLK_DIV;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] mem_address;
    logic [31:0] mem_write_value;
    logic [31:0] status;
    logic        uart_tx;

    int total = 0;
    int bad   = 0;

    uart_tx_mmio #(
        .CLK_DIV(CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TX_ADDR(TX_ADDR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .we(we),
        .mem_address(mem_address),
        .mem_write_value(mem_write_value),
        .status(status),
        .uart_tx(uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];
    bit         m_valid = 0;
    bit         m_act   = 0;
    int         m_pos   = 0;
    logic [7:0] m_byte  = '0;
    bit         m_ovf   = 0;
    logic       m_line  = 1'b1;
    logic       m_nl;
    bit         m_full_pre;

    // Line level at a given cycle offset within a frame of byte b
    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        int k;
        k = pos / CLK_DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_act   = 0;
            m_pos   = 0;
            m_ovf   = 0;
            m_line  = 1'b1;
            m_valid = 1;
        end else begin
            m_nl       = m_act ? frame_bit(m_byte, m_pos) : 1'b1;
            m_full_pre = (mq.size() == FIFO_DEPTH);
            if (m_act && m_pos != FRAME - 1) begin
                m_pos++;
            end else if (mq.size() != 0) begin
                m_byte = mq.pop_front();
                m_act  = 1;
                m_pos  = 0;
            end else begin
                m_act = 0;
            end
            if (we && mem_address == TX_ADDR) begin
                if (m_full_pre) m_ovf = 1;
                else mq.push_back(mem_write_value[7:0]);
            end else if (we && mem_address == TX_ADDR + 32'd4 && mem_write_value[0]) begin
                m_ovf = 0;
            end
            m_line = m_nl;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model line", 32'(uart_tx), 32'(m_line));
            check("model status", status,
                  {24'b0, 4'(mq.size()), 1'b0, m_ovf,
                   (mq.size() == FIFO_DEPTH), (m_act || mq.size() != 0)});
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; the store lands on the following posedge.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1;
        mem_address = a;
        mem_write_value = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (status[0] && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain busy", 32'(status[0]), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    int slots[NSLOT];
    int n;

    initial begin
        rst = 1'b1;
        we = 1'b0;
        mem_address = '0;
        mem_write_value = '0;
        repeat (3) @(negedge clk);
        check("reset status", status, 32'h0);
        check("reset line", 32'(uart_tx), 32'h1);
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0x55: start, 1,0,1,0,1,0,1,0, [parity 0], stop
`ifdef UART_TX_PARITY_EN
        slots = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
`else
        slots = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif
        store(TX_ADDR, 32'h55);
        for (int i = 1; i <= BUSY_END; i++) begin
            @(negedge clk);
            if (i == 1) check("55 before start", 32'(uart_tx), 32'h1);
            else check("55 frame bit", 32'(uart_tx), 32'(slots[(i - 2) / 4]));
            if (i == BUSY_END - 1) check("55 busy held", 32'(status[0]), 32'h1);
            if (i == BUSY_END) check("55 busy end", 32'(status[0]), 32'h0);
        end
        wait_idle(50);

        // Five back-to-back stores from idle
        for (int i = 1; i <= 5; i++) store(TX_ADDR, 32'(i));
        check("b2b status", status, 32'h43);
        n = 0;
        while (status[0] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("b2b drain cycles", 32'(n), 32'(DRAIN5));
        check("b2b overflow", 32'(status[2]), 32'h0);
        wait_idle(10);

        // Overflow: sixth store dropped, clear via control register
        for (int i = 0; i < 6; i++) store(TX_ADDR, 32'h21 + 32'(i));
        check("ovf status", status, 32'h47);
        store(TX_ADDR + 32'd4, 32'h2);
        check("ovf kept on bit0=0", status, 32'h47);
        store(TX_ADDR + 32'd4, 32'h1);
        check("ovf cleared", status, 32'h43);
        wait_idle(600);

        // Unmapped address
        store(TX_ADDR + 32'd8, 32'hA7);
        repeat (6) begin
            check("bad addr status", status, 32'h0);
            check("bad addr line", 32'(uart_tx), 32'h1);
            @(negedge clk);
        end

        // Push coinciding with end-of-frame pop at count=2
        store(TX_ADDR, 32'h31);
        store(TX_ADDR, 32'h32);
        store(TX_ADDR, 32'h33);
        repeat (FRAME - 2) @(negedge clk);
        check("pre concurrent count", 32'(status[7:4]), 32'h2);
        store(TX_ADDR, 32'h34);
        check("post concurrent count", 32'(status[7:4]), 32'h2);
        wait_idle(400);

        // Reset during data bit 3 with two bytes queued, plus a store
        store(TX_ADDR, 32'h41);
        store(TX_ADDR, 32'h42);
        store(TX_ADDR, 32'h43);
        repeat (15) @(negedge clk);
        check("pre-reset count", 32'(status[7:4]), 32'h2);
        check("pre-reset line bit2", 32'(uart_tx), 32'h0);
        rst = 1'b1;
        we = 1'b1;
        mem_address = TX_ADDR;
        mem_write_value = 32'h99;
        @(negedge clk);
        rst = 1'b0;
        we = 1'b0;
        check("mid-frame rst status", status, 32'h0);
        check("mid-frame rst line", 32'(uart_tx), 32'h1);
        repeat (2 * FRAME) begin
            @(negedge clk);
            check("post-rst status", status, 32'h0);
            check("post-rst line", 32'(uart_tx), 32'h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, clk cycles per serial bit (legal 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, TX FIFO entries (legal 2, 4, 8).
REQ-003 SHALL have parameter TX_ADDR, default 32'h0000_F000, data register byte address; control register at TX_ADDR+4.
REQ-004 SHALL have port clk  input  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port we  input  1  CPU store strobe, one cycle per store.
REQ-007 SHALL have port mem_address  input  32  CPU store byte address.
REQ-008 SHALL have port mem_write_value  input  32  CPU store data.
REQ-009 SHALL have port status  output  32  {24'b0, count[3:0], 1'b0, overflow, full, busy}.
REQ-010 SHALL have port uart_tx  output  1  serial line, idle high.

Function
REQ-011 SHALL push mem_write_value[7:0] into the FIFO on a rising edge with we=1, mem_address==TX_ADDR and full=0; other addresses are ignored except REQ-013.
REQ-012 SHALL drop a data write arriving with full=1 and set overflow sticky, even if a pop occurs in the same cycle.
REQ-013 SHALL clear overflow on we=1, mem_address==TX_ADDR+4, mem_write_value[0]=1; a simultaneous overflow-set and clear SHALL leave overflow=1.
REQ-014 SHALL drive status combinationally from registered state: count = FIFO occupancy, full = (count==FIFO_DEPTH), busy = (state!=IDLE)|(count!=0).
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY (only if REQ-027), STOP.
REQ-016 IDLE: uart_tx=1; when count!=0, pop head into shift register and enter START at that edge.
REQ-017 START: uart_tx=0 for exactly CLK_DIV cycles, then DATA.
REQ-018 DATA: 8 bits LSB first, each held exactly CLK_DIV cycles, bit index 0..7, then PARITY or STOP.
REQ-019 STOP: uart_tx=1 for CLK_DIV cycles; at its last cycle pop and go to START if count!=0, else IDLE (no idle gap between back-to-back frames).
REQ-020 Bit timing SHALL use a down-counter loaded with CLK_DIV-1 at every state/bit entry; advance on counter==0.
REQ-021 Latency: a write accepted at edge N into an empty, idle block SHALL drive uart_tx=0 from edge N+2.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-023 uart_tx SHALL be driven from a flop (glitch-free).

Reset
REQ-024 On rst=1 at a rising edge: state=IDLE, uart_tx=1, FIFO empty (count=0), overflow=0, counters zero; status=32'h0 next cycle.
REQ-025 rst mid-frame SHALL abort the frame immediately (uart_tx=1 after that edge) and discard queued bytes.
REQ-026 A write coinciding with rst SHALL be discarded.

Configuration
REQ-027 With UART_TX_PARITY_EN defined: PARITY state after DATA drives even parity (XOR of 8 data bits) for CLK_DIV cycles; frame = 11*CLK_DIV cycles.
REQ-028 Without UART_TX_PARITY_EN: no PARITY state or logic; frame = 10*CLK_DIV cycles.

Verification
REQ-029 CLK_DIV=4, write 8'h55 to TX_ADDR -> uart_tx low from edge N+2, bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high, busy=0 after 40 cycles (44 with parity, parity bit 0).
REQ-030 Five back-to-back writes 8'h01..8'h05, FIFO_DEPTH=4, idle block -> first popped immediately, all five transmitted contiguously, overflow=0.
REQ-031 Six writes while busy with FIFO full from cycle 2 -> sixth dropped, status[2]=1, full=1; write 1 to TX_ADDR+4 -> overflow=0.
REQ-032 Write 8'hA7 to TX_ADDR+8 -> no push, count=0, uart_tx stays 1.
REQ-033 rst asserted during DATA bit 3 with 2 bytes queued -> next cycle uart_tx=1, status=0, no further frames.
REQ-034 Push concurrent with STOP-end pop at count=2 -> count stays 2, byte order preserved on the line.
